// File: rtl/cam_flash_pkg.sv
// Shared definitions for the CAM <-> flash transfer engines.
// Holds the default geometry and the saver state encoding.
package cam_flash_pkg;

  localparam int CAM_ADDR_W = 4;
  localparam int CAM_DATA_W = 32;
  localparam int ENTRIES    = 2 ** CAM_ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WAIT_RDY,
    S_PROG,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FIN,
    S_ERR
  } state_t;

  function automatic logic is_wait(state_t s);
    return (s == S_WAIT_RDY) ||
           (s == S_WAIT_ACK) ||
           (s == S_WAIT_DONE);
  endfunction

endpackage

// File: rtl/cam_flash_saver_wait_timer.sv
// Clearable saturating cycle counter for the flash wait states.
// expired stays high once the count reaches TIMEOUT.
module wait_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/cam_flash_saver.sv
// Write-back engine: copies every CAM entry into flash, one word
// per address, using the flash busy handshake with a wait timeout.
module cam_flash_saver
  import cam_flash_pkg::*;
#(
  parameter int ADDR_W  = CAM_ADDR_W,
  parameter int DATA_W  = CAM_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_req,
  output logic              cam_rd_en,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_rd_data,
  output logic              flash_wr_en,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_wr_data,
  input  logic              flash_busy,
  output logic              active,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data_q;
  logic              tmr_clr;
  logic              tmr_exp;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .expired(tmr_exp)
  );

  // A busy transition always wins over a timeout on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (save_req) state_nxt = S_RD;
      end
      S_RD: state_nxt = S_CAP;
      S_CAP: begin
        state_nxt = flash_busy ? S_WAIT_RDY : S_PROG;
      end
      S_WAIT_RDY: begin
        if (!flash_busy)  state_nxt = S_PROG;
        else if (tmr_exp) state_nxt = S_ERR;
      end
      S_PROG: state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (flash_busy)   state_nxt = S_WAIT_DONE;
        else if (tmr_exp) state_nxt = S_ERR;
      end
      S_WAIT_DONE: begin
        if (!flash_busy)
          state_nxt = (idx == LAST_IDX) ? S_FIN : S_RD;
        else if (tmr_exp)
          state_nxt = S_ERR;
      end
      S_FIN:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tmr_clr = is_wait(state_nxt) && (state_nxt != state);

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      data_q      <= '0;
      cam_rd_en   <= 1'b0;
      flash_wr_en <= 1'b0;
      active      <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cam_rd_en   <= (state_nxt == S_RD);
      flash_wr_en <= (state_nxt == S_PROG);
      active      <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_FIN) ||
                     (state_nxt == S_ERR);
      if (state == S_IDLE && save_req) begin
        idx   <= '0;
        error <= 1'b0;
      end
      if (state == S_WAIT_DONE && state_nxt == S_RD)
        idx <= idx + 1'b1;
      if (state == S_CAP)
        data_q <= cam_rd_data;
      if (state_nxt == S_ERR)
        error <= 1'b1;
    end
  end

  assign cam_addr      = idx;
  assign flash_addr    = idx;
  assign flash_wr_data = data_q;

endmodule
